regfile_reader: RTL and testbench

Sequential read-out engine for the calculator's 16×32 register file. On a start pulse it walks a contiguous address range using the register file's two read ports (`dirA`/`dirB`) and fetches two registers per access. It emits each value with its address on a valid/ready stream for the display/debug path. It is the read-side counterpart of the writeback path that drives `reg_write`/`dir_WR`/`data_in`.

---
 rtl/regfile_reader_if.sv | 25 ++
 rtl/regfile_reader.sv | 153 +++++++++++++++
 tb/tb_regfile_reader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_reader_if.sv
// Output stream of the register file read-out engine.
// Valid/ready word stream carrying one register and its address.
interface regfile_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_dir;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_dir,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_dir,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/regfile_reader.sv
// Sequential dump of a register file address range, two reads per fetch.
// Emits each word with its address on a valid/ready stream.
module regfile_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_dir,
  input  logic [ADDR_W-1:0] last_dir,
  output logic [ADDR_W-1:0] dirA,
  output logic [ADDR_W-1:0] dirB,
  input  logic [DATA_W-1:0] datA,
  input  logic [DATA_W-1:0] datB,
  regfile_reader_if.master  stream,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_A,
    SEND_B,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_n;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] end_dir;
  logic [ADDR_W-1:0] end_n;
  logic [DATA_W-1:0] buf_a;
  logic [DATA_W-1:0] buf_a_n;
  logic [DATA_W-1:0] buf_b;
  logic [DATA_W-1:0] buf_b_n;
  logic              err_q;
  logic              err_n;
  logic              hs;

  assign ptr_inc = ptr + ADDR_W'(1);
  assign dirA    = ptr;
  assign dirB    = ptr_inc;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = err_q;
  assign hs      = stream.out_valid
                 & stream.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      end_dir <= '0;
      buf_a   <= '0;
      buf_b   <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr     <= ptr_n;
      end_dir <= end_n;
      buf_a   <= buf_a_n;
      buf_b   <= buf_b_n;
      err_q   <= err_n;
    end
  end

  // End checks use ptr before any increment, so a range
  // ending at the top address never wraps into an extra word.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    end_n   = end_dir;
    buf_a_n = buf_a;
    buf_b_n = buf_b;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (first_dir <= last_dir) begin
            ptr_n   = first_dir;
            end_n   = last_dir;
            state_n = FETCH;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      FETCH: begin
        buf_a_n = datA;
        buf_b_n = datB;
        state_n = SEND_A;
      end
      SEND_A: begin
        if (hs) begin
          if (ptr == end_dir) begin
            state_n = DONE;
          end else begin
            state_n = SEND_B;
          end
        end
      end
      SEND_B: begin
        if (hs) begin
          if (ptr_inc == end_dir) begin
            state_n = DONE;
          end else begin
            ptr_n   = ptr + ADDR_W'(2);
            state_n = FETCH;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    stream.out_valid = 1'b0;
    stream.out_dir   = '0;
    stream.out_data  = '0;
    unique case (1'b1)
      (state == SEND_A): begin
        stream.out_valid = 1'b1;
        stream.out_dir   = ptr;
        stream.out_data  = buf_a;
      end
      (state == SEND_B): begin
        stream.out_valid = 1'b1;
        stream.out_dir   = ptr_inc;
        stream.out_data  = buf_b;
      end
      default: begin
        stream.out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: range dumps, stalls,
// rejected start, ignored start and mid-transfer reset.
module tb_regfile_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  first_dir = '0;
  logic [3:0]  last_dir = '0;
  logic [3:0]  dirA;
  logic [3:0]  dirB;
  logic [31:0] datA;
  logic [31:0] datB;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] rf [16];
  logic [31:0] golden [16];

  int tests = 0;
  int fails = 0;

  regfile_reader_if #(.DATA_W(32), .ADDR_W(4)) sif ();

  regfile_reader #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_dir (first_dir),
    .last_dir  (last_dir),
    .dirA      (dirA),
    .dirB      (dirB),
    .datA      (datA),
    .datB      (datB),
    .stream    (sif.master),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign datA = rf[dirA];
  assign datB = rf[dirB];

  typedef struct {
    logic [3:0] first;
    logic [3:0] last;
    bit         stall;
    bit         restart;
    int         nexp;
    int         last_edge;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, " out_valid"}, 32'(sif.out_valid), 0);
    chk({tag, " out_dir"}, 32'(sif.out_dir), 0);
    chk({tag, " out_data"}, sif.out_data, 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " dirA"}, 32'(dirA), 0);
    chk({tag, " dirB"}, 32'(dirB), 1);
  endtask

  task automatic run_dump(input logic [3:0] f,
                          input logic [3:0] l,
                          input bit stall,
                          input bit restart,
                          input int nexp,
                          input int last_edge);
    int          cyc;
    int          words;
    int          last_hs;
    int          done_cyc;
    bit          held;
    bit          err_seen;
    logic [3:0]  h_dir;
    logic [31:0] h_data;
    logic [3:0]  e_dir;
    @(negedge clk);
    first_dir = f;
    last_dir  = l;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    words    = 0;
    last_hs  = -1;
    done_cyc = -1;
    held     = 1'b0;
    err_seen = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      sif.out_ready = stall ? (cyc % 3 == 2) : 1'b1;
      if (restart && cyc == 3) begin
        first_dir = 4'd9;
        last_dir  = 4'd2;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (err) err_seen = 1'b1;
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (held) begin
          chk("stall valid", 32'(sif.out_valid), 1);
          chk("stall dir", 32'(sif.out_dir), 32'(h_dir));
          chk("stall data", sif.out_data, h_data);
        end
        held = 1'b0;
        if (sif.out_valid && sif.out_ready) begin
          e_dir = f + 4'(words);
          if (words >= nexp) begin
            chk("extra word", 32'(sif.out_dir), 32'hFFFF);
          end else begin
            chk("word dir", 32'(sif.out_dir), 32'(e_dir));
            chk("word data", sif.out_data, golden[e_dir]);
          end
          words++;
          last_hs = cyc;
        end else if (sif.out_valid) begin
          held   = 1'b1;
          h_dir  = sif.out_dir;
          h_data = sif.out_data;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done seen", 32'(done_cyc >= 0), 1);
    chk("word count", 32'(words), 32'(nexp));
    chk("done timing", 32'(done_cyc), 32'(last_hs + 1));
    if (last_edge >= 0)
      chk("last edge", 32'(last_hs), 32'(last_edge));
    if (restart)
      chk("busy start err", 32'(err_seen), 0);
    @(negedge clk);
    chk("done pulse", 32'(done), 0);
    chk("busy after", 32'(busy), 0);
    chk("valid after", 32'(sif.out_valid), 0);
  endtask

  initial begin
    golden = '{32'd1, 32'd12, 32'd123, 32'd1234,
               32'd2345, 32'd3456, 32'd4567, 32'd5678,
               32'd6789, 32'd12345, 32'd23456, 32'h0,
               32'h0, 32'h0, 32'hAAAA5555, 32'hDEADBEEF};
    rf = golden;
    sif.out_ready = 1'b0;

    vecs[0] = '{4'd0, 4'd10, 1'b0, 1'b0, 11, 17};
    vecs[1] = '{4'd3, 4'd3, 1'b0, 1'b0, 1, 2};
    vecs[2] = '{4'd14, 4'd15, 1'b0, 1'b0, 2, 3};
    vecs[3] = '{4'd0, 4'd5, 1'b1, 1'b0, 6, -1};
    vecs[4] = '{4'd4, 4'd9, 1'b0, 1'b1, 6, 9};

    #2 rst_n = 1'b0;
    #20;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      rf[0] = (vecs[i].first == 4'd14) ? 32'd7 : golden[0];
      run_dump(vecs[i].first, vecs[i].last, vecs[i].stall,
               vecs[i].restart, vecs[i].nexp,
               vecs[i].last_edge);
    end
    rf[0] = golden[0];

    @(negedge clk);
    first_dir = 4'd9;
    last_dir  = 4'd2;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("err pulse", 32'(err), 1);
    chk("err busy", 32'(busy), 0);
    chk("err valid", 32'(sif.out_valid), 0);
    @(negedge clk);
    chk("err drop", 32'(err), 0);
    chk("err busy2", 32'(busy), 0);
    chk("err valid2", 32'(sif.out_valid), 0);

    sif.out_ready = 1'b1;
    first_dir = 4'd0;
    last_dir  = 4'd10;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst pre A", 32'(sif.out_dir), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst pre valid", 32'(sif.out_valid), 1);
    chk("rst pre B", 32'(sif.out_dir), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_dump(4'd4, 4'd5, 1'b0, 1'b0, 2, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
